// File: rtl/inst_cache_dm.sv
// Direct-mapped, read-allocate instruction cache, one word per line.
// Writes bypass the cache and invalidate a matching line.
module inst_cache_dm #(
  parameter int INDEX_WIDTH = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic        cache_req,
  output logic        cache_wr,
  output logic [1:0]  cache_size,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  input  logic [31:0] cache_rdata,
  input  logic        cache_addr_ok,
  input  logic        cache_data_ok
);

  localparam int TAG_W = 30 - INDEX_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    REFILL,
    WSEND,
    WWAIT
  } state_e;

  state_e state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   accept;
  logic                   fill_en;

  assign idx = addr_q[INDEX_WIDTH+1:2];
  assign tag = addr_q[31:INDEX_WIDTH+2];
  assign hit = valid_q[idx] & (tag_q[idx] == tag);

  // Next state, handshake outputs and valid-bit updates.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    fill_en     = 1'b0;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = 32'h0;
    cache_req   = 1'b0;
    cache_wr    = 1'b0;
    cache_size  = 2'd0;
    cache_addr  = 32'h0;
    cache_wdata = 32'h0;
    unique case (state_q)
      IDLE: begin
        // Gate with reset so every output reads 0 while held in reset.
        cpu_addr_ok = cpu_req & resetn;
        if (cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (wr_q) begin
          if (hit) valid_d[idx] = 1'b0;
          state_d = WSEND;
        end else if (hit) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = data_q[idx];
          state_d     = IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        cache_req  = 1'b1;
        cache_size = 2'd2;
        cache_addr = {addr_q[31:2], 2'b00};
        if (cache_addr_ok) state_d = REFILL;
      end
      REFILL: begin
        if (cache_data_ok) begin
          fill_en      = 1'b1;
          valid_d[idx] = 1'b1;
          cpu_data_ok  = 1'b1;
          cpu_rdata    = cache_rdata;
          state_d      = IDLE;
        end
      end
      WSEND: begin
        cache_req   = 1'b1;
        cache_wr    = 1'b1;
        cache_size  = size_q;
        cache_addr  = addr_q;
        cache_wdata = wdata_q;
        if (cache_addr_ok) state_d = WWAIT;
      end
      WWAIT: begin
        if (cache_data_ok) begin
          cpu_data_ok = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = cpu_req & cpu_addr_ok;

  // Request latch: captured only on the accepting cycle.
  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    if (accept) begin
      addr_d  = cpu_addr;
      wr_d    = cpu_wr;
      size_d  = cpu_size;
      wdata_d = cpu_wdata;
    end
  end

  // State, request latch and valid bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= 32'h0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= cache_rdata;
    end
  end

endmodule

// File: doc/inst_cache_dm.md
Name: inst_cache_dm

Overview:
- Direct-mapped, read-allocate instruction cache with one 32-bit word per line.
- Sits between the instruction sram-to-sram-like converter (CPU side) and the sram-like instruction port of cpu_axi_interface (memory side).
- Read hits are served in 1 cycle after acceptance. Read misses refill one word from memory and return it.
- Write requests are forwarded uncached; they invalidate any matching line.

Parameters:
- INDEX_WIDTH, 7, log2 of line count (128 lines); tag width = 30 - INDEX_WIDTH.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request valid
- cpu_wr  in  1  1 = write
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_addr  in  32  physical address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid with cpu_data_ok
- cpu_addr_ok  out  1  request accepted
- cpu_data_ok  out  1  response done
- cache_req  out  1  memory request valid
- cache_wr  out  1  memory write
- cache_size  out  2  memory size
- cache_addr  out  32  memory address
- cache_wdata  out  32  memory write data
- cache_rdata  in  32  memory read data
- cache_addr_ok  in  1  memory accepted request
- cache_data_ok  in  1  memory response done

Behaviour:
- Address split: tag = addr[31:INDEX_WIDTH+2], index = addr[INDEX_WIDTH+1:2], addr[1:0] ignored for lookup.
- Storage: valid[], tag[], data[] register arrays.
- Reset (async, resetn=0): all valid bits cleared, state=IDLE, all outputs 0 (cpu_rdata = 0, cache_* = 0). Tag/data arrays are not reset.
- Reset mid-miss abandons the transaction; the memory side shares the same reset.
- One outstanding CPU request at a time. The request is latched (addr, wr, size, wdata) on cpu_req & cpu_addr_ok.
- IDLE:
  - cpu_addr_ok = cpu_req (combinational).
  - On accept -> LOOKUP.
- LOOKUP (1 cycle):
  - hit = valid[idx] & (tag[idx] == latched tag).
  - Read hit: cpu_data_ok=1, cpu_rdata=data[idx] this cycle -> IDLE. Hit latency is therefore addr_ok at cycle N, data_ok at cycle N+1.
  - Read miss -> MISS.
  - Write: if hit, clear valid[idx] -> WSEND.
- MISS:
  - cache_req=1, cache_wr=0, cache_size=2, cache_addr={latched addr[31:2],2'b00}.
  - Held stable until cache_addr_ok; then cache_req drops next cycle -> REFILL.
- REFILL:
  - Waits for cache_data_ok.
  - On that cycle: data[idx]<=cache_rdata, tag[idx]<=latched tag, valid[idx]<=1, cpu_data_ok=1, cpu_rdata=cache_rdata (combinational pass-through) -> IDLE.
- WSEND:
  - cache_req=1, cache_wr=1, cache_size/cache_addr/cache_wdata = latched values, unmodified.
  - Until cache_addr_ok -> WWAIT.
- WWAIT:
  - On cache_data_ok: cpu_data_ok=1 -> IDLE.
- cpu_addr_ok=0 in every state except IDLE. cpu_data_ok is a single-cycle pulse per accepted request.
- cache_addr_ok and cache_data_ok in the same cycle while in MISS or WSEND: treated as addr_ok only. The memory side never asserts data_ok before the cycle after addr_ok.
- Back-to-back: a new cpu_req in the cycle after data_ok (IDLE) is accepted immediately. There are no idle bubbles beyond the LOOKUP cycle.
- Index conflict: a refill overwrites the line regardless of prior valid (no victim handling, read-only data).
- Same-index write then read: the read misses (line was invalidated) and refetches.

Test Plan:
- Reset then read 0xBFC00000 (memory returns 0x3C1DBFC0 two cycles after addr_ok) -> exactly one cache_req with addr 0xBFC00000, size 2; cpu_data_ok with 0x3C1DBFC0; valid[0] set.
- Repeat read 0xBFC00000 -> cpu_addr_ok cycle N, cpu_data_ok cycle N+1 with 0x3C1DBFC0; cache_req stays 0.
- Read 0xBFC00200 (same index, different tag, INDEX_WIDTH=7) -> miss, refill replaces line. A following read of 0xBFC00000 misses again.
- Write 0xBFC00000 data 0x12345678 size 2 -> cache_wr=1 forwarded with same addr/data; line invalidated. A following read misses and fetches from memory.
- Read miss with cache_addr_ok delayed 5 cycles -> cache_req and cache_addr held stable all 5 cycles; no cpu_data_ok until cache_data_ok.
- Assert resetn=0 during REFILL -> outputs 0 immediately; after release the state is IDLE, all lines invalid, and the next read misses.
